// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch/loader/memory handshake bundle for imem_arbiter
interface imem_arbiter_if;
  logic        fetch_req;
  logic [6:0]  fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        ld_req;
  logic [6:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter between fetch and loader
// Optional anti-starvation counter enabled by macro IMEM_ARB_FAIRNESS_EN.
module imem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_load_mode,
  output logic [7:0]          o_ld_count,
  imem_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    FETCH_PRI = 2'd0,
    LOAD_PRI  = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_fetch_gnt;
  logic        w_ld_gnt;
  logic        w_contend;
  logic        w_fair_take;
  logic        w_enter_load;
  logic        r_fetch_rvalid;
  logic [7:0]  r_ld_count;

  assign w_contend    = bus.fetch_req & bus.ld_req;
  assign w_enter_load = (r_state == FETCH_PRI) && (w_state_next == LOAD_PRI);

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int FAIR_W = $clog2(STARVE_LIMIT + 1);
  logic [FAIR_W-1:0] r_fair_cnt;
  logic              w_pri_gnt;

  assign w_fair_take = w_contend && (r_fair_cnt >= FAIR_W'(STARVE_LIMIT));
  assign w_pri_gnt   = (r_state == LOAD_PRI) ? w_ld_gnt : w_fetch_gnt;

  // Counts priority wins only while the other side is waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fair_cnt <= '0;
    end else if ((w_state_next != r_state) || !w_contend || !w_pri_gnt) begin
      r_fair_cnt <= '0;
    end else begin
      r_fair_cnt <= r_fair_cnt + FAIR_W'(1);
    end
  end
`else
  assign w_fair_take = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH_PRI;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_PRI: if (i_load_mode)  w_state_next = LOAD_PRI;
      LOAD_PRI:  if (!i_load_mode) w_state_next = DRAIN;
      DRAIN:     w_state_next = FETCH_PRI;
      default:   w_state_next = FETCH_PRI;
    endcase
  end

  // DRAIN and reset give no grants so the last loader write lands before any fetch.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_ld_gnt    = 1'b0;
    if (reset) begin
      case (r_state)
        FETCH_PRI: begin
          w_fetch_gnt = bus.fetch_req & ~w_fair_take;
          w_ld_gnt    = bus.ld_req & (~bus.fetch_req | w_fair_take);
        end
        LOAD_PRI: begin
          w_ld_gnt    = bus.ld_req & ~w_fair_take;
          w_fetch_gnt = bus.fetch_req & (~bus.ld_req | w_fair_take);
        end
        default: begin
          w_fetch_gnt = 1'b0;
          w_ld_gnt    = 1'b0;
        end
      endcase
    end

    bus.mem_addr  = 7'd0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'd0;
    if (w_ld_gnt) begin
      bus.mem_addr  = bus.ld_addr;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = bus.ld_wdata;
    end else if (w_fetch_gnt) begin
      bus.mem_addr  = bus.fetch_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_rvalid <= 1'b0;
    end else begin
      r_fetch_rvalid <= w_fetch_gnt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ld_count <= 8'd0;
    end else if (w_enter_load) begin
      r_ld_count <= 8'd0;
    end else if (w_ld_gnt && (r_ld_count != 8'hFF)) begin
      r_ld_count <= r_ld_count + 8'd1;
    end
  end

  assign bus.fetch_gnt    = w_fetch_gnt;
  assign bus.ld_gnt       = w_ld_gnt;
  assign bus.fetch_rvalid = r_fetch_rvalid;
  assign bus.fetch_rdata  = r_fetch_rvalid ? bus.mem_rdata : 32'd0;
  assign o_ld_count       = r_ld_count;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
  logic        clock;
  logic        reset;
  logic        load_mode;
  logic [7:0]  ld_count;
  logic [31:0] mem [0:127];
  int          n_tests;
  int          n_fail;

  imem_arbiter_if bus ();

  imem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_load_mode (load_mode),
    .o_ld_count  (ld_count),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic f_req, input logic [6:0] f_addr,
                       input logic l_req, input logic [6:0] l_addr, input logic [31:0] l_data);
    bus.fetch_req  = f_req;
    bus.fetch_addr = f_addr;
    bus.ld_req     = l_req;
    bus.ld_addr    = l_addr;
    bus.ld_wdata   = l_data;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    load_mode = 1'b0;
    drive(1'b1, 7'h01, 1'b1, 7'h02, 32'hAAAA5555);
    tick;
    n_tests++; if (bus.fetch_gnt !== 1'b0 || bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: fetch=%b ld=%b want 0 0", bus.fetch_gnt, bus.ld_gnt); end
    n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    n_tests++; if (bus.fetch_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.fetch_rvalid); end
    n_tests++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", ld_count); end
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
    reset = 1'b1;
    tick;
  endtask

  task automatic test_fetch_read;
    drive(1'b1, 7'h05, 1'b0, 7'h00, 32'h0);
    n_tests++; if (bus.fetch_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL read_gnt: fetch=%b ld=%b want 1 0", bus.fetch_gnt, bus.ld_gnt); end
    n_tests++; if (bus.mem_addr !== 7'h05 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL read_mem: addr=%h we=%b want 05 0", bus.mem_addr, bus.mem_we); end
    tick;
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
    n_tests++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: rvalid=%b rdata=%h want 1 deadbeef", bus.fetch_rvalid, bus.fetch_rdata); end
    n_tests++; if (bus.mem_addr !== 7'h00 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL idle_mem: addr=%h wdata=%h want 00 0", bus.mem_addr, bus.mem_wdata); end
    tick;
    n_tests++; if (bus.fetch_rvalid !== 1'b0 || bus.fetch_rdata !== 32'h0) begin n_fail++; $display("FAIL read_idle: rvalid=%b rdata=%h want 0 0", bus.fetch_rvalid, bus.fetch_rdata); end
  endtask

  task automatic test_fetch_priority;
    drive(1'b1, 7'h11, 1'b1, 7'h03, 32'hCAFE0003);
    n_tests++; if (bus.fetch_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL fpri_both: fetch=%b ld=%b want 1 0", bus.fetch_gnt, bus.ld_gnt); end
    tick;
    drive(1'b0, 7'h11, 1'b1, 7'h03, 32'hCAFE0003);
    n_tests++; if (bus.ld_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 7'h03 || bus.mem_wdata !== 32'hCAFE0003) begin
      n_fail++; $display("FAIL fpri_ld: gnt=%b we=%b addr=%h wdata=%h want 1 1 03 cafe0003", bus.ld_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    tick;
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
  endtask

  task automatic test_load_drain;
    load_mode = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      logic [6:0]  a;
      logic [31:0] d;
      a = 7'(9 - i);
      d = (i == 9) ? 32'h12345678 : 32'h100 + 32'(i);
      if (i == 9) begin
        load_mode = 1'b0;
        drive(1'b1, 7'h00, 1'b1, a, d);
      end else begin
        drive(1'b0, 7'h00, 1'b1, a, d);
      end
      n_tests++; if (bus.ld_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== a) begin
        n_fail++; $display("FAIL load_wr%0d: ld=%b fetch=%b we=%b addr=%h want 1 0 1 %h", i, bus.ld_gnt, bus.fetch_gnt, bus.mem_we, bus.mem_addr, a); end
      tick;
    end
    drive(1'b1, 7'h00, 1'b1, 7'h05, 32'hBAD0BAD0);
    n_tests++; if (bus.fetch_gnt !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL drain: fetch=%b ld=%b we=%b want 0 0 0", bus.fetch_gnt, bus.ld_gnt, bus.mem_we); end
    n_tests++; if (ld_count !== 8'd10) begin n_fail++; $display("FAIL load_count: got %0d want 10", ld_count); end
    tick;
    drive(1'b1, 7'h00, 1'b0, 7'h00, 32'h0);
    n_tests++; if (bus.fetch_gnt !== 1'b1 || bus.mem_addr !== 7'h00) begin n_fail++; $display("FAIL post_drain_gnt: fetch=%b addr=%h want 1 00", bus.fetch_gnt, bus.mem_addr); end
    tick;
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
    n_tests++; if (bus.fetch_rvalid !== 1'b1 || bus.fetch_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL drain_read: rvalid=%b rdata=%h want 1 12345678", bus.fetch_rvalid, bus.fetch_rdata); end
  endtask

  task automatic test_fairness;
    logic [9:0] exp_f;
`ifdef IMEM_ARB_FAIRNESS_EN
    exp_f = 10'b10000_10000;
`else
    exp_f = 10'b00000_00000;
`endif
    load_mode = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 7'h07, 1'b1, 7'h40, 32'h0);
      n_tests++; if (bus.fetch_gnt !== exp_f[i] || bus.ld_gnt !== ~exp_f[i]) begin
        n_fail++; $display("FAIL fair_c%0d: fetch=%b ld=%b want %b %b", i, bus.fetch_gnt, bus.ld_gnt, exp_f[i], ~exp_f[i]); end
      tick;
    end
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
  endtask

  task automatic test_saturation;
    load_mode = 1'b0;
    tick;
    tick;
    load_mode = 1'b1;
    tick;
    n_tests++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d want 0", ld_count); end
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 7'h00, 1'b1, 7'(i + 16), 32'(i));
      tick;
      if (i == 253) begin
        n_tests++; if (ld_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", ld_count); end
      end
      if (i == 254) begin
        n_tests++; if (ld_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", ld_count); end
      end
    end
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
    n_tests++; if (ld_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", ld_count); end
  endtask

  task automatic test_reset_inflight;
    drive(1'b1, 7'h05, 1'b0, 7'h00, 32'h0);
    n_tests++; if (bus.fetch_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL lpri_fetch: fetch=%b ld=%b want 1 0", bus.fetch_gnt, bus.ld_gnt); end
    tick;
    reset = 1'b0;
    drive(1'b1, 7'h05, 1'b1, 7'h06, 32'h0);
    n_tests++; if (bus.fetch_rvalid !== 1'b0 || bus.fetch_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rvalid: rvalid=%b rdata=%h want 0 0", bus.fetch_rvalid, bus.fetch_rdata); end
    n_tests++; if (bus.fetch_gnt !== 1'b0 || bus.ld_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_gnt: fetch=%b ld=%b we=%b want 0 0 0", bus.fetch_gnt, bus.ld_gnt, bus.mem_we); end
    n_tests++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", ld_count); end
    load_mode = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    n_tests++; if (bus.fetch_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_state: fetch=%b ld=%b want 1 0", bus.fetch_gnt, bus.ld_gnt); end
    tick;
    drive(1'b0, 7'h00, 1'b0, 7'h00, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;
    test_reset;
    test_fetch_read;
    test_fetch_priority;
    test_load_drain;
    test_fairness;
    test_saturation;
    test_reset_inflight;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive grants to the priority requester while the other waits.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 load_mode  input  1  level; 1 = loader has priority (RAM initialization), 0 = fetch has priority.
REQ-005 fetch_req  input  1  fetch read request.
REQ-006 fetch_addr  input  7  fetch word address (PC[8:2]).
REQ-007 fetch_gnt  output  1  fetch request accepted this cycle.
REQ-008 fetch_rvalid  output  1  fetch read data valid.
REQ-009 fetch_rdata  output  32  fetch read data.
REQ-010 ld_req  input  1  loader write request.
REQ-011 ld_addr  input  7  loader word address.
REQ-012 ld_wdata  input  32  loader write data.
REQ-013 ld_gnt  output  1  loader write accepted this cycle.
REQ-014 mem_addr  output  7  single-port memory address.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data, synchronous, 1-cycle latency.
REQ-018 ld_count  output  8  words written since the last entry into LOAD_PRI.

Function
REQ-019 FSM states FETCH_PRI, LOAD_PRI, DRAIN; FETCH_PRI->LOAD_PRI when load_mode=1; LOAD_PRI->DRAIN when load_mode=0; DRAIN->FETCH_PRI unconditionally after one cycle.
REQ-020 Grants are decided combinationally from the current state, requests and fairness counter; a load_mode change takes effect the cycle after it is sampled.
REQ-021 At most one of fetch_gnt, ld_gnt is 1 in any cycle; a grant is only given to an asserted request.
REQ-022 FETCH_PRI: fetch wins if both request; loader is granted when fetch_req=0.
REQ-023 LOAD_PRI: loader wins if both request; fetch is granted when ld_req=0.
REQ-024 DRAIN: no grants, mem_we=0; guarantees the last write commits before any fetch read.
REQ-025 On ld_gnt: mem_addr=ld_addr, mem_wdata=ld_wdata, mem_we=1; on fetch_gnt: mem_addr=fetch_addr, mem_we=0; no grant: mem_addr=0, mem_we=0, mem_wdata=0.
REQ-026 fetch_rvalid is fetch_gnt registered by one cycle; fetch_rdata equals mem_rdata when fetch_rvalid=1, else 0.
REQ-027 ld_count clears on the FETCH_PRI->LOAD_PRI transition, increments on each ld_gnt, saturates at 255, holds otherwise.
REQ-028 Back-to-back grants to the same requester are allowed every cycle; no idle cycle is inserted except DRAIN.

Reset
REQ-029 Reset assertion immediately forces state FETCH_PRI, fetch_rvalid=0, ld_count=0, fairness counter=0, regardless of any in-flight read.
REQ-030 While reset=0 all grants and mem_we are 0; the first grant can occur in the first clock edge after release.

Configuration
REQ-031 Macro IMEM_ARB_FAIRNESS_EN: when defined, a counter counts consecutive priority-requester grants while the other requester is asserted and waiting; on reaching STARVE_LIMIT the next contended cycle grants the non-priority requester and the counter clears.
REQ-032 The counter clears on any cycle without contention and on every state transition.
REQ-033 Without IMEM_ARB_FAIRNESS_EN: strict priority per REQ-022/023; the non-priority requester may starve indefinitely.

Verification
REQ-034 FETCH_PRI, fetch_req=1 addr 0x05, mem returns 0xDEADBEEF -> fetch_gnt=1 cycle N, fetch_rvalid=1 and fetch_rdata=0xDEADBEEF cycle N+1.
REQ-035 load_mode=1, ld_req held 10 cycles, addr 0..9 -> ten writes with mem_we=1, ld_count=10; load_mode=0 -> one DRAIN cycle with no grants, then FETCH_PRI.
REQ-036 Fairness on, LOAD_PRI, ld_req and fetch_req both held -> pattern 4 ld_gnt, 1 fetch_gnt, repeating; fairness off -> fetch_gnt never asserted.
REQ-037 260 loader writes in one LOAD_PRI session -> ld_count saturates at 255.
REQ-038 Reset asserted the cycle after a fetch_gnt -> fetch_rvalid=0 immediately, no grants during reset, state FETCH_PRI after release.
REQ-039 Write 0x12345678 to addr 0x00 as last loader write, then load_mode=0 with fetch_req addr 0x00 pending -> fetch granted only after DRAIN, returns 0x12345678.
